// File: rtl/debug_control_memory_burst_pkg.sv
// Types and constants shared by the debug-unit controllers.
package debug_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_READ,
    ST_WAIT,
    ST_SEND,
    ST_DONE
  } debug_state_t;

  localparam logic [5:0] CTRL_ID_MEMORY_BURST    = 6'b000000;
  localparam logic [5:0] CTRL_ID_REGISTER_FILE   = 6'b000001;
  localparam logic [5:0] CTRL_ID_PROGRAM_COUNTER = 6'b000010;
  localparam logic [5:0] CTRL_ID_STEP            = 6'b000011;

  // Number of frames needed to carry one memory word.
  function automatic int n_chunk(input int nb_data, input int nb_frame);
    return (nb_data + nb_frame - 1) / nb_frame;
  endfunction

endpackage

// File: rtl/debug_control_memory_burst_if.sv
// Debug-interface and data-memory signals of the burst memory controller.
interface debug_control_memory_burst_if #(
  parameter int NB_DATA          = 32,
  parameter int NB_CONTROL_FRAME = 32,
  parameter int NB_ADDR          = 10,
  parameter int NB_REQUEST       = 6
);

  logic [NB_REQUEST-1:0]       i_request_select;
  logic [NB_ADDR-1:0]          i_base_addr;
  logic [NB_ADDR:0]            i_num_words;
  logic [NB_ADDR-1:0]          o_mem_addr;
  logic                        o_mem_re;
  logic [NB_DATA-1:0]          i_data_from_mips;
  logic [NB_CONTROL_FRAME-1:0] o_frame_to_interface;
  logic                        o_frame_valid;
  logic                        i_frame_ready;
  logic                        o_writing;
  logic                        o_done;

  modport master (
    output i_request_select, i_base_addr, i_num_words, i_data_from_mips, i_frame_ready,
    input  o_mem_addr, o_mem_re, o_frame_to_interface, o_frame_valid, o_writing, o_done
  );

  modport slave (
    input  i_request_select, i_base_addr, i_num_words, i_data_from_mips, i_frame_ready,
    output o_mem_addr, o_mem_re, o_frame_to_interface, o_frame_valid, o_writing, o_done
  );

endinterface

// File: rtl/debug_control_memory_burst_serializer.sv
// Splits one memory word into frames, least-significant chunk first, the
// last chunk zero-extended.
module debug_frame_serializer
  import debug_pkg::*;
#(
  parameter int NB_DATA          = 32,
  parameter int NB_CONTROL_FRAME = 32
) (
  input  logic                        clock,
  input  logic                        reset,
  input  logic                        load,
  input  logic [NB_DATA-1:0]          word,
  input  logic                        send,
  input  logic                        ready,
  output logic [NB_CONTROL_FRAME-1:0] frame,
  output logic                        last_accepted
);

  localparam int N_CHUNK      = n_chunk(NB_DATA, NB_CONTROL_FRAME);
  localparam int NB_PAD       = N_CHUNK * NB_CONTROL_FRAME;
  localparam int NB_CHUNK_CNT = (N_CHUNK > 1) ? $clog2(N_CHUNK) : 1;

  logic [NB_PAD-1:0]       shift_q;
  logic [NB_CHUNK_CNT-1:0] chunk_cnt;
  logic                    last_chunk;
  logic                    advance;

  assign last_chunk    = (chunk_cnt == NB_CHUNK_CNT'(N_CHUNK - 1));
  assign advance       = send & ready & ~last_chunk;
  assign last_accepted = send & ready & last_chunk;

  // The low frame of the shift register is the frame on the wire, so the
  // output comes straight from flops and zero-fill happens on the shift.
  always_ff @(posedge clock) begin
    if (reset) begin
      shift_q   <= '0;
      chunk_cnt <= '0;
    end else if (load) begin
      shift_q   <= NB_PAD'(word);
      chunk_cnt <= '0;
    end else if (advance) begin
      shift_q   <= shift_q >> NB_CONTROL_FRAME;
      chunk_cnt <= chunk_cnt + NB_CHUNK_CNT'(1);
    end
  end

  assign frame = shift_q[NB_CONTROL_FRAME-1:0];

endmodule

// File: rtl/debug_control_memory_burst.sv
// Burst memory-read controller: streams a block of data-memory words to the
// debug interface when its controller ID is requested.
//
//   state   | meaning
//   IDLE    | waiting for a rising edge of the registered request match
//   READ    | memory read strobe for the current address
//   WAIT    | read data arrives, loaded into the serializer
//   SEND    | frames offered with valid/ready
//   DONE    | one-cycle completion pulse
module debug_control_memory_burst
  import debug_pkg::*;
#(
  parameter int                    NB_DATA          = 32,
  parameter int                    NB_CONTROL_FRAME = 32,
  parameter int                    NB_ADDR          = 10,
  parameter int                    NB_REQUEST       = 6,
  parameter logic [NB_REQUEST-1:0] CONTROLLER_ID    = NB_REQUEST'(CTRL_ID_MEMORY_BURST)
) (
  input logic                         i_clock,
  input logic                         i_reset,
  debug_control_memory_burst_if.slave bus
);

  localparam int NB_COUNT = NB_ADDR + 1;

  debug_state_t        state;
  logic                match_q;
  logic                match_prev;
  logic [NB_ADDR-1:0]  addr_cnt;
  logic [NB_COUNT-1:0] word_cnt;
  logic                mem_re_q;
  logic                frame_valid_q;
  logic                done_q;
  logic                writing_q;
  logic                start;
  logic                last_word;
  logic                last_accepted;

  assign start     = match_q & ~match_prev;
  assign last_word = (word_cnt == NB_COUNT'(1));

  debug_frame_serializer #(
    .NB_DATA          (NB_DATA),
    .NB_CONTROL_FRAME (NB_CONTROL_FRAME)
  ) u_serializer (
    .clock         (i_clock),
    .reset         (i_reset),
    .load          (state == ST_WAIT),
    .word          (bus.i_data_from_mips),
    .send          (state == ST_SEND),
    .ready         (bus.i_frame_ready),
    .frame         (bus.o_frame_to_interface),
    .last_accepted (last_accepted)
  );

  // Outputs are registered alongside the state so they line up with it.
  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      state         <= ST_IDLE;
      match_q       <= 1'b0;
      match_prev    <= 1'b0;
      addr_cnt      <= '0;
      word_cnt      <= '0;
      mem_re_q      <= 1'b0;
      frame_valid_q <= 1'b0;
      done_q        <= 1'b0;
      writing_q     <= 1'b0;
    end else begin
      match_q    <= (bus.i_request_select == CONTROLLER_ID);
      match_prev <= match_q;
      mem_re_q   <= 1'b0;
      done_q     <= 1'b0;
      unique case (state)
        ST_IDLE: begin
          if (start) begin
            addr_cnt  <= bus.i_base_addr;
            word_cnt  <= bus.i_num_words;
            writing_q <= 1'b1;
            if (bus.i_num_words == '0) begin
              state  <= ST_DONE;
              done_q <= 1'b1;
            end else begin
              state    <= ST_READ;
              mem_re_q <= 1'b1;
            end
          end
        end
        ST_READ: begin
          if (!match_q) begin
            state     <= ST_IDLE;
            writing_q <= 1'b0;
          end else begin
            state <= ST_WAIT;
          end
        end
        ST_WAIT: begin
          if (!match_q) begin
            state     <= ST_IDLE;
            writing_q <= 1'b0;
          end else begin
            state         <= ST_SEND;
            frame_valid_q <= 1'b1;
          end
        end
        ST_SEND: begin
          // A withdrawn request wins even over a frame accepted this cycle.
          if (!match_q) begin
            state         <= ST_IDLE;
            writing_q     <= 1'b0;
            frame_valid_q <= 1'b0;
          end else if (last_accepted) begin
            frame_valid_q <= 1'b0;
            if (last_word) begin
              state  <= ST_DONE;
              done_q <= 1'b1;
            end else begin
              word_cnt <= word_cnt - NB_COUNT'(1);
              addr_cnt <= addr_cnt + NB_ADDR'(1);
              state    <= ST_READ;
              mem_re_q <= 1'b1;
            end
          end
        end
        ST_DONE: begin
          state     <= ST_IDLE;
          writing_q <= 1'b0;
        end
        default: begin
          state         <= ST_IDLE;
          writing_q     <= 1'b0;
          frame_valid_q <= 1'b0;
        end
      endcase
    end
  end

  assign bus.o_mem_addr    = addr_cnt;
  assign bus.o_mem_re      = mem_re_q;
  assign bus.o_frame_valid = frame_valid_q;
  assign bus.o_done        = done_q;
  assign bus.o_writing     = writing_q;

endmodule

// File: tb/tb_debug_control_memory_burst.sv
// Bench for the burst memory controller with 8-, 32- and 12-bit frame widths.
module tb_debug_control_memory_burst;
  import debug_pkg::*;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  debug_control_memory_burst_if #(.NB_DATA(32), .NB_CONTROL_FRAME(8),  .NB_ADDR(10), .NB_REQUEST(6)) bus8 ();
  debug_control_memory_burst_if #(.NB_DATA(32), .NB_CONTROL_FRAME(32), .NB_ADDR(10), .NB_REQUEST(6)) bus32 ();
  debug_control_memory_burst_if #(.NB_DATA(32), .NB_CONTROL_FRAME(12), .NB_ADDR(10), .NB_REQUEST(6)) bus12 ();

  debug_control_memory_burst #(.NB_DATA(32), .NB_CONTROL_FRAME(8), .NB_ADDR(10), .NB_REQUEST(6),
    .CONTROLLER_ID(6'b000000)) dut8 (.i_clock(clk), .i_reset(rst), .bus(bus8));
  debug_control_memory_burst #(.NB_DATA(32), .NB_CONTROL_FRAME(32), .NB_ADDR(10), .NB_REQUEST(6),
    .CONTROLLER_ID(6'b000000)) dut32 (.i_clock(clk), .i_reset(rst), .bus(bus32));
  debug_control_memory_burst #(.NB_DATA(32), .NB_CONTROL_FRAME(12), .NB_ADDR(10), .NB_REQUEST(6),
    .CONTROLLER_ID(6'b000000)) dut12 (.i_clock(clk), .i_reset(rst), .bus(bus12));

  logic [31:0] mem [0:1023];

  // Data memory: read data valid the cycle after the read strobe.
  always @(posedge clk) begin
    if (bus8.o_mem_re)  bus8.i_data_from_mips  <= mem[bus8.o_mem_addr];
    if (bus32.o_mem_re) bus32.i_data_from_mips <= mem[bus32.o_mem_addr];
    if (bus12.o_mem_re) bus12.i_data_from_mips <= mem[bus12.o_mem_addr];
  end

  typedef struct {
    logic [5:0]  req;
    logic [9:0]  base;
    logic [10:0] num;
    logic        ready;
    logic        mem_re;
    logic [9:0]  addr;
    logic        valid;
    logic [7:0]  frame;
    logic        done;
    logic        writing;
  } vec_t;

  localparam int NV = 23;
  vec_t vecs [NV];

  int checks = 0;
  int errors = 0;
  int na, nf, done_cyc, seen, ndone, nre, nvalid, first_frame;
  logic [9:0]  wrap_addr [4] = '{10'h3FE, 10'h3FF, 10'h000, 10'h001};
  logic [31:0] w12;

  function automatic vec_t mk(input logic [5:0] req, input logic [9:0] base, input logic [10:0] num,
                              input logic ready, input logic mem_re, input logic [9:0] addr,
                              input logic valid, input logic [7:0] frame, input logic done,
                              input logic writing);
    vec_t v;
    v.req = req; v.base = base; v.num = num; v.ready = ready; v.mem_re = mem_re;
    v.addr = addr; v.valid = valid; v.frame = frame; v.done = done; v.writing = writing;
    return v;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    for (int i = 0; i < 1024; i++) mem[i] = 32'h9E3779B9 * (i + 1);
    mem[10'h010] = 32'hDEADBEEF;
    mem[10'h020] = 32'h11223344;
    mem[10'h005] = 32'hDEADBEEF;

    // req, base, num, ready | mem_re, addr, valid, frame, done, writing
    vecs[0]  = mk(6'h00, 10'h010, 11'd1, 1'b1, 1'b0, 10'h000, 1'b0, 8'h00, 1'b0, 1'b0);
    vecs[1]  = mk(6'h00, 10'h010, 11'd1, 1'b1, 1'b1, 10'h010, 1'b0, 8'h00, 1'b0, 1'b1);
    vecs[2]  = mk(6'h00, 10'h010, 11'd1, 1'b1, 1'b0, 10'h010, 1'b0, 8'h00, 1'b0, 1'b1);
    vecs[3]  = mk(6'h00, 10'h010, 11'd1, 1'b1, 1'b0, 10'h010, 1'b1, 8'hEF, 1'b0, 1'b1);
    vecs[4]  = mk(6'h00, 10'h010, 11'd1, 1'b1, 1'b0, 10'h010, 1'b1, 8'hBE, 1'b0, 1'b1);
    vecs[5]  = mk(6'h00, 10'h010, 11'd1, 1'b1, 1'b0, 10'h010, 1'b1, 8'hAD, 1'b0, 1'b1);
    vecs[6]  = mk(6'h00, 10'h010, 11'd1, 1'b1, 1'b0, 10'h010, 1'b1, 8'hDE, 1'b0, 1'b1);
    vecs[7]  = mk(6'h00, 10'h010, 11'd1, 1'b1, 1'b0, 10'h010, 1'b0, 8'h00, 1'b1, 1'b1);
    vecs[8]  = mk(6'h00, 10'h010, 11'd1, 1'b1, 1'b0, 10'h010, 1'b0, 8'h00, 1'b0, 1'b0);
    vecs[9]  = mk(6'h00, 10'h010, 11'd1, 1'b1, 1'b0, 10'h010, 1'b0, 8'h00, 1'b0, 1'b0);
    vecs[10] = mk(6'h00, 10'h010, 11'd1, 1'b1, 1'b0, 10'h010, 1'b0, 8'h00, 1'b0, 1'b0);
    vecs[11] = mk(6'h3F, 10'h020, 11'd1, 1'b1, 1'b0, 10'h010, 1'b0, 8'h00, 1'b0, 1'b0);
    vecs[12] = mk(6'h00, 10'h020, 11'd1, 1'b1, 1'b0, 10'h010, 1'b0, 8'h00, 1'b0, 1'b0);
    vecs[13] = mk(6'h00, 10'h020, 11'd1, 1'b1, 1'b1, 10'h020, 1'b0, 8'h00, 1'b0, 1'b1);
    vecs[14] = mk(6'h00, 10'h020, 11'd1, 1'b1, 1'b0, 10'h020, 1'b0, 8'h00, 1'b0, 1'b1);
    vecs[15] = mk(6'h00, 10'h020, 11'd1, 1'b0, 1'b0, 10'h020, 1'b1, 8'h44, 1'b0, 1'b1);
    vecs[16] = mk(6'h00, 10'h020, 11'd1, 1'b1, 1'b0, 10'h020, 1'b1, 8'h33, 1'b0, 1'b1);
    vecs[17] = mk(6'h00, 10'h020, 11'd1, 1'b0, 1'b0, 10'h020, 1'b1, 8'h33, 1'b0, 1'b1);
    vecs[18] = mk(6'h00, 10'h020, 11'd1, 1'b0, 1'b0, 10'h020, 1'b1, 8'h33, 1'b0, 1'b1);
    vecs[19] = mk(6'h00, 10'h020, 11'd1, 1'b1, 1'b0, 10'h020, 1'b1, 8'h22, 1'b0, 1'b1);
    vecs[20] = mk(6'h00, 10'h020, 11'd1, 1'b1, 1'b0, 10'h020, 1'b1, 8'h11, 1'b0, 1'b1);
    vecs[21] = mk(6'h00, 10'h020, 11'd1, 1'b1, 1'b0, 10'h020, 1'b0, 8'h00, 1'b1, 1'b1);
    vecs[22] = mk(6'h00, 10'h020, 11'd1, 1'b1, 1'b0, 10'h020, 1'b0, 8'h00, 1'b0, 1'b0);

    rst = 1'b1;
    bus8.i_request_select  = 6'h3F; bus8.i_base_addr  = '0; bus8.i_num_words  = '0; bus8.i_frame_ready  = 1'b1;
    bus32.i_request_select = 6'h3F; bus32.i_base_addr = '0; bus32.i_num_words = '0; bus32.i_frame_ready = 1'b1;
    bus12.i_request_select = 6'h3F; bus12.i_base_addr = '0; bus12.i_num_words = '0; bus12.i_frame_ready = 1'b1;
    tick(); tick();
    check("reset mem_re",  32'(bus8.o_mem_re), 0);
    check("reset addr",    32'(bus8.o_mem_addr), 0);
    check("reset valid",   32'(bus8.o_frame_valid), 0);
    check("reset frame",   32'(bus8.o_frame_to_interface), 0);
    check("reset done",    32'(bus8.o_done), 0);
    check("reset writing", 32'(bus8.o_writing), 0);
    check("reset writing32", 32'(bus32.o_writing), 0);
    check("reset frame12", 32'(bus12.o_frame_to_interface), 0);
    rst = 1'b0;
    tick();

    // Single 4-chunk word, then held request, then ready pattern 1,0,0,1.
    for (int k = 0; k < NV; k++) begin
      bus8.i_request_select = vecs[k].req;
      bus8.i_base_addr      = vecs[k].base;
      bus8.i_num_words      = vecs[k].num;
      bus8.i_frame_ready    = vecs[k].ready;
      tick();
      check($sformatf("v%0d mem_re", k),  32'(bus8.o_mem_re),      32'(vecs[k].mem_re));
      check($sformatf("v%0d addr", k),    32'(bus8.o_mem_addr),    32'(vecs[k].addr));
      check($sformatf("v%0d valid", k),   32'(bus8.o_frame_valid), 32'(vecs[k].valid));
      check($sformatf("v%0d done", k),    32'(bus8.o_done),        32'(vecs[k].done));
      check($sformatf("v%0d writing", k), 32'(bus8.o_writing),     32'(vecs[k].writing));
      if (vecs[k].valid)
        check($sformatf("v%0d frame", k), 32'(bus8.o_frame_to_interface), 32'(vecs[k].frame));
    end

    // Zero-word request: done two cycles after the request edge, nothing read or sent.
    bus8.i_request_select = 6'h3F; tick();
    bus8.i_num_words = 11'd0; bus8.i_base_addr = 10'h100; bus8.i_request_select = 6'h00;
    nre = 0; nvalid = 0; ndone = 0; done_cyc = -1;
    for (int cyc = 1; cyc <= 8; cyc++) begin
      tick();
      nre += int'(bus8.o_mem_re);
      nvalid += int'(bus8.o_frame_valid);
      ndone += int'(bus8.o_done);
      if (bus8.o_done && done_cyc < 0) done_cyc = cyc;
    end
    check("count0 done cycle", 32'(done_cyc), 2);
    check("count0 done pulses", 32'(ndone), 1);
    check("count0 mem_re", 32'(nre), 0);
    check("count0 valid", 32'(nvalid), 0);

    // Wrapping four-word burst with 32-bit frames.
    bus32.i_base_addr = 10'h3FE; bus32.i_num_words = 11'd4; bus32.i_frame_ready = 1'b1;
    bus32.i_request_select = 6'h00;
    na = 0; nf = 0; done_cyc = -1;
    for (int cyc = 1; cyc <= 30 && done_cyc < 0; cyc++) begin
      tick();
      if (bus32.o_mem_re) begin
        if (na < 4) check($sformatf("wrap addr %0d", na), 32'(bus32.o_mem_addr), 32'(wrap_addr[na]));
        na++;
      end
      if (bus32.o_frame_valid) begin
        if (nf < 4) check($sformatf("wrap frame %0d", nf), bus32.o_frame_to_interface, mem[wrap_addr[nf]]);
        nf++;
      end
      if (bus32.o_done) done_cyc = cyc;
    end
    check("wrap reads", 32'(na), 4);
    check("wrap frames", 32'(nf), 4);
    check("wrap done cycle", 32'(done_cyc), 14);
    bus32.i_request_select = 6'h3F;

    // 12-bit frames: three chunks, the last zero-extended.
    w12 = mem[10'h005];
    bus12.i_base_addr = 10'h005; bus12.i_num_words = 11'd1; bus12.i_request_select = 6'h00;
    nf = 0; nre = 0; done_cyc = -1;
    for (int cyc = 1; cyc <= 20 && done_cyc < 0; cyc++) begin
      tick();
      nre += int'(bus12.o_mem_re);
      if (bus12.o_frame_valid) begin
        if (nf < 3) check($sformatf("chunk12 %0d", nf), 32'(bus12.o_frame_to_interface),
                          (w12 >> (12 * nf)) & 32'h0000_0FFF);
        nf++;
      end
      if (bus12.o_done) done_cyc = cyc;
    end
    check("chunk12 frames", 32'(nf), 3);
    check("chunk12 reads", 32'(nre), 1);
    check("chunk12 done cycle", 32'(done_cyc), 7);
    bus12.i_request_select = 6'h3F;

    // Request withdrawn while a frame is stalled.
    bus8.i_request_select = 6'h3F; tick();
    bus8.i_base_addr = 10'h030; bus8.i_num_words = 11'd2; bus8.i_frame_ready = 1'b0;
    bus8.i_request_select = 6'h00;
    seen = 0;
    for (int c = 0; c < 10 && seen == 0; c++) begin
      tick();
      seen = int'(bus8.o_frame_valid);
    end
    check("abort reached send", 32'(seen), 1);
    check("abort stalled frame", 32'(bus8.o_frame_to_interface), 32'(mem[10'h030][7:0]));
    bus8.i_request_select = 6'h3F;
    tick(); tick();
    check("abort valid", 32'(bus8.o_frame_valid), 0);
    check("abort writing", 32'(bus8.o_writing), 0);
    ndone = 0;
    for (int c = 0; c < 6; c++) begin
      tick();
      ndone += int'(bus8.o_done);
    end
    check("abort no done", 32'(ndone), 0);

    // Reset during WAIT, then a fresh request with a new base address.
    bus8.i_base_addr = 10'h040; bus8.i_num_words = 11'd1; bus8.i_frame_ready = 1'b1;
    bus8.i_request_select = 6'h00;
    tick(); tick();
    check("rstwait read", 32'(bus8.o_mem_re), 1);
    check("rstwait addr", 32'(bus8.o_mem_addr), 32'h040);
    tick();
    rst = 1'b1;
    tick();
    check("rstwait mem_re", 32'(bus8.o_mem_re), 0);
    check("rstwait addr0", 32'(bus8.o_mem_addr), 0);
    check("rstwait valid", 32'(bus8.o_frame_valid), 0);
    check("rstwait frame", 32'(bus8.o_frame_to_interface), 0);
    check("rstwait done", 32'(bus8.o_done), 0);
    check("rstwait writing", 32'(bus8.o_writing), 0);
    rst = 1'b0;
    bus8.i_request_select = 6'h3F; bus8.i_base_addr = 10'h050;
    tick();
    bus8.i_request_select = 6'h00;
    tick(); tick();
    check("restart read", 32'(bus8.o_mem_re), 1);
    check("restart addr", 32'(bus8.o_mem_addr), 32'h050);
    first_frame = -1; done_cyc = -1;
    for (int cyc = 3; cyc <= 20 && done_cyc < 0; cyc++) begin
      tick();
      if (bus8.o_frame_valid && first_frame < 0) first_frame = int'(bus8.o_frame_to_interface);
      if (bus8.o_done) done_cyc = cyc;
    end
    check("restart first frame", 32'(first_frame), 32'(mem[10'h050][7:0]));
    check("restart done cycle", 32'(done_cyc), 8);
    bus8.i_request_select = 6'h3F;
    tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
